// File: rtl/fifo_reader.sv
// fifo_reader: drains a push/pop FIFO one word at a time and sends each word
// as a serial frame (start bit low, DATA_W data bits LSB first, stop bit high).
module fifo_reader #(
   parameter int DATA_W       = 16,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              fifo_emp,
   input  logic [DATA_W-1:0] fifo_data,
   output logic              pop,
   output logic              tx,
   output logic              busy,
   output logic              word_done,
   output logic [7:0]        words_sent
);

   typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP} state_t;

   localparam logic [7:0] TMR_LAST = 8'(CLKS_PER_BIT - 1);
   localparam logic [4:0] IDX_LAST = 5'(DATA_W - 1);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] sh_q, sh_d;
   logic [7:0]        tmr_q, tmr_d;
   logic [4:0]        idx_q, idx_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              tx_q, tx_d;
   logic              bit_end;

   assign bit_end = (tmr_q == TMR_LAST);

   // Next-state, datapath and strobe decode; a new word is only started
   // from IDLE or at the end of a stop bit.
   always_comb begin
      state_d   = state_q;
      sh_d      = sh_q;
      tmr_d     = tmr_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      pop       = 1'b0;
      word_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable && !fifo_emp) state_d = FETCH;
         end
         FETCH: begin
            pop     = 1'b1;
            sh_d    = fifo_data;
            tmr_d   = 8'd0;
            idx_d   = 5'd0;
            state_d = START;
         end
         START: begin
            if (bit_end) begin
               tmr_d   = 8'd0;
               state_d = DATA;
            end else begin
               tmr_d = tmr_q + 8'd1;
            end
         end
         DATA: begin
            if (bit_end) begin
               tmr_d = 8'd0;
               sh_d  = sh_q >> 1;
               idx_d = idx_q + 5'd1;
               if (idx_q == IDX_LAST) state_d = STOP;
            end else begin
               tmr_d = tmr_q + 8'd1;
            end
         end
         STOP: begin
            if (bit_end) begin
               word_done = 1'b1;
               cnt_d     = cnt_q + 8'd1;
               tmr_d     = 8'd0;
               state_d   = (enable && !fifo_emp) ? FETCH : IDLE;
            end else begin
               tmr_d = tmr_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      // tx is registered, so it is computed for the state being entered.
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = sh_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   // State and datapath registers; reset forces the line idle-high at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         sh_q    <= '0;
         tmr_q   <= 8'd0;
         idx_q   <= 5'd0;
         cnt_q   <= 8'd0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         tmr_q   <= tmr_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         tx_q    <= tx_d;
      end
   end

   assign tx         = tx_q;
   assign busy       = (state_q != IDLE);
   assign words_sent = cnt_q;

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: directed + random stimulus against a frame-timing reference
// model and an independent serial receiver.
module tb_fifo_reader;

   localparam int C      = 4;
   localparam int DW     = 16;
   localparam int FRAME  = 18 * C;
   localparam int PERIOD = 18 * C + 1;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        enable = 1'b0;
   logic        fifo_emp;
   logic [15:0] fifo_data;
   logic        pop, tx, busy, word_done;
   logic [7:0]  words_sent;

   // FIFO stand-in: head word visible while non-empty, pop consumes at the edge
   logic [15:0] fmem [0:1023];
   logic [31:0] rd_ptr = 32'd0;
   logic [31:0] wr_ptr = 32'd0;
   assign fifo_emp  = (rd_ptr == wr_ptr);
   assign fifo_data = fmem[rd_ptr[9:0]];

   always @(posedge clk) if (pop && !fifo_emp) rd_ptr <= rd_ptr + 32'd1;

   always #5 clk = ~clk;

   fifo_reader #(.DATA_W(DW), .CLKS_PER_BIT(C)) dut (
      .clk(clk), .rst(rst), .enable(enable), .fifo_emp(fifo_emp),
      .fifo_data(fifo_data), .pop(pop), .tx(tx), .busy(busy),
      .word_done(word_done), .words_sent(words_sent)
   );

   // ---------------- reference model (frame timeline by cycle arithmetic) ----
   int          cyc, fs, mk, mb, wd_cnt;
   logic        in_frame, pend;
   logic [15:0] fw, rxw;
   logic [7:0]  exp_cnt, exp_ws;
   logic        exp_pop, exp_tx, exp_busy, exp_wd;
   int          pop_cyc[$];
   logic [15:0] rx_q[$];

   initial begin : model
      cyc = 0; fs = 0; mk = 0; mb = 0; wd_cnt = 0;
      in_frame = 1'b0; pend = 1'b0; fw = '0; rxw = '0; exp_cnt = '0;
      exp_pop = 1'b0; exp_tx = 1'b1; exp_busy = 1'b0; exp_wd = 1'b0; exp_ws = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (pop) pop_cyc.push_back(cyc);
         if (!rst) begin
            in_frame = 1'b0; pend = 1'b0; exp_cnt = '0;
            exp_pop = 1'b0; exp_tx = 1'b1; exp_busy = 1'b0; exp_wd = 1'b0; exp_ws = '0;
         end else begin
            exp_pop = pend;
            pend = 1'b0;
            if (exp_pop) begin in_frame = 1'b1; fs = cyc; fw = fifo_data; end
            mk = cyc - fs;
            exp_busy = in_frame;
            exp_tx = 1'b1;
            if (in_frame && mk > 0) begin
               mb = (mk - 1) / C;
               if (mb == 0) exp_tx = 1'b0;
               else if (mb <= DW) exp_tx = fw[mb-1];
               // receiver: sample mid-bit from the line itself
               if (mb >= 1 && mb <= DW && ((mk - 1) % C) == C / 2) rxw[mb-1] = tx;
            end
            exp_wd = in_frame && (mk == FRAME);
            exp_ws = exp_cnt;
            if (exp_wd) begin
               exp_cnt++; wd_cnt++; rx_q.push_back(rxw); in_frame = 1'b0;
            end
            if (!in_frame && enable && !fifo_emp) pend = 1'b1;
         end
      end
   end

   // ---------------- checking / stimulus ----------------
   int nchk = 0;
   int nerr = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      nchk++;
      assert (obs === exp_v) else begin
         nerr++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // one clock: compare outputs against the model mid-cycle, return after the edge
   task automatic step();
      @(negedge clk);
      #1;
      chk("pop", {31'd0, pop}, {31'd0, exp_pop});
      chk("tx", {31'd0, tx}, {31'd0, exp_tx});
      chk("busy", {31'd0, busy}, {31'd0, exp_busy});
      chk("word_done", {31'd0, word_done}, {31'd0, exp_wd});
      chk("words_sent", {24'd0, words_sent}, {24'd0, exp_ws});
      if (pop) chk("pop_on_empty", {31'd0, fifo_emp}, 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] w);
      fmem[wr_ptr[9:0]] = w;
      wr_ptr = wr_ptr + 32'd1;
   endtask

   task automatic drain(input int maxc);
      int n;
      n = 0;
      do begin step(); n++; end while ((!fifo_emp || busy) && n < maxc);
      chk("drain_timeout", {31'd0, n < maxc}, 32'd1);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      step(); step();
      rst = 1'b1;
      step();
   endtask

   task automatic wait_pop(input int base);
      int n;
      n = 0;
      while (pop_cyc.size() == base && n < 20) begin step(); n++; end
      chk("pop_wait_timeout", {31'd0, n < 20}, 32'd1);
   endtask

   initial begin : main
      int bp, br, bw, n;
      logic [15:0] words4 [4];
      logic [15:0] rnd_q[$];
      words4[0] = 16'h0001; words4[1] = 16'h8000; words4[2] = 16'hFFFF; words4[3] = 16'h0000;

      // reset state
      step(); step();
      chk("rst_tx", {31'd0, tx}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_pop", {31'd0, pop}, 32'd0);
      chk("rst_ws", {24'd0, words_sent}, 32'd0);
      rst = 1'b1;
      step();

      // single word A5C3
      bp = pop_cyc.size(); br = rx_q.size(); bw = wd_cnt;
      enable = 1'b1;
      push(16'hA5C3);
      drain(200);
      chk("t1_pops", pop_cyc.size() - bp, 32'd1);
      chk("t1_rx_n", rx_q.size() - br, 32'd1);
      if (rx_q.size() > br) chk("t1_word", {16'd0, rx_q[br]}, 32'h0000A5C3);
      chk("t1_done", wd_cnt - bw, 32'd1);
      chk("t1_ws", {24'd0, words_sent}, 32'd1);
      chk("t1_busy", {31'd0, busy}, 32'd0);

      // full FIFO, back-to-back
      do_reset();
      bp = pop_cyc.size(); br = rx_q.size();
      for (int i = 0; i < 4; i++) push(words4[i]);
      drain(600);
      chk("t2_pops", pop_cyc.size() - bp, 32'd4);
      if (pop_cyc.size() - bp == 4)
         for (int i = 0; i < 3; i++)
            chk("t2_spacing", pop_cyc[bp+i+1] - pop_cyc[bp+i], PERIOD);
      chk("t2_rx_n", rx_q.size() - br, 32'd4);
      if (rx_q.size() - br == 4)
         for (int i = 0; i < 4; i++) chk("t2_word", {16'd0, rx_q[br+i]}, {16'd0, words4[i]});
      chk("t2_ws", {24'd0, words_sent}, 32'd4);
      chk("t2_busy", {31'd0, busy}, 32'd0);

      // enable low holds off the pop
      enable = 1'b0;
      push(16'h1234);
      for (int i = 0; i < 100; i++) begin
         step();
         chk("t3_nopop", {31'd0, pop}, 32'd0);
         chk("t3_tx", {31'd0, tx}, 32'd1);
         chk("t3_busy", {31'd0, busy}, 32'd0);
      end
      enable = 1'b1;
      step();
      chk("t3_pop_next", {31'd0, pop}, 32'd1);
      drain(200);

      // enable dropped mid-DATA of word 1 of 2
      bp = pop_cyc.size(); br = rx_q.size();
      push(16'h0F0F); push(16'hBEEF);
      wait_pop(bp);
      repeat (30) step();
      enable = 1'b0;
      n = 0;
      while (busy && n < 200) begin step(); n++; end
      chk("t4_idle_timeout", {31'd0, n < 200}, 32'd1);
      repeat (20) step();
      chk("t4_pops", pop_cyc.size() - bp, 32'd1);
      chk("t4_rx_n", rx_q.size() - br, 32'd1);
      if (rx_q.size() > br) chk("t4_word", {16'd0, rx_q[br]}, 32'h00000F0F);
      chk("t4_left", {31'd0, fifo_emp}, 32'd0);
      chk("t4_busy", {31'd0, busy}, 32'd0);
      enable = 1'b1;
      drain(200);

      // async reset mid-DATA
      do_reset();
      bp = pop_cyc.size();
      push(16'h1357);
      wait_pop(bp);
      repeat (30) step();
      #1 rst = 1'b0;
      #1;
      chk("t5_tx", {31'd0, tx}, 32'd1);
      chk("t5_busy", {31'd0, busy}, 32'd0);
      chk("t5_ws", {24'd0, words_sent}, 32'd0);
      push(16'h2468);
      step(); step();
      br = rx_q.size();
      rst = 1'b1;
      drain(200);
      chk("t5_rx_n", rx_q.size() - br, 32'd1);
      if (rx_q.size() > br) chk("t5_word", {16'd0, rx_q[br]}, 32'h00002468);
      chk("t5_ws_after", {24'd0, words_sent}, 32'd1);

      // 257 random words: counter wrap
      do_reset();
      br = rx_q.size(); bw = wd_cnt;
      for (int i = 0; i < 257; i++) begin
         rnd_q.push_back(16'($urandom));
         push(rnd_q[i]);
      end
      n = 0;
      while (wd_cnt - bw < 256 && n < 257 * PERIOD + 200) begin step(); n++; end
      chk("t6_ws_wrap", {24'd0, words_sent}, 32'd0);
      while (wd_cnt - bw < 257 && n < 257 * PERIOD + 200) begin step(); n++; end
      chk("t6_ws_257", {24'd0, words_sent}, 32'd1);
      drain(200);
      chk("t6_rx_n", rx_q.size() - br, 32'd257);
      if (rx_q.size() - br == 257)
         for (int i = 0; i < 257; i++) chk("t6_word", {16'd0, rx_q[br+i]}, {16'd0, rnd_q[i]});

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
